// File: rtl/vend_fsm_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module   : vend_fsm_ctrl_p
// Purpose  : Vending-machine controller for NUM_PRODUCTS products. It checks
//            affordability against a per-product price vector, runs its own
//            selection and dispense timers, retries a stalled dispense and
//            refunds with a sticky fault once retries are exhausted.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            credit                      - live credit from coin accumulator
//            price_vec, stock_empty      - per-product price / sold-out flags
//            sel_valid, sel_id, cancel   - user selection strobe and cancel
//            product_dispense_done       - dispenser completion
//            change_dispense_done        - change unit completion
//            state_out                   - current state encoding
//            dispense_en, dispense_id    - dispenser request and product id
//            change_en, change_amount    - change/refund request and amount
//            credit_clear                - one-cycle "zero your credit" pulse
//            sel_reject                  - one-cycle invalid/sold-out pulse
//            display_amount_en           - high in WAIT_COIN and SELECT
//            fault                       - sticky dispense fault
// Revision : 1.0 - initial release
// ============================================================================
module vend_fsm_ctrl_p #(
  parameter int NUM_PRODUCTS     = 4,
  parameter int PRICE_W          = 8,
  parameter int SELECT_TIMEOUT   = 1000,
  parameter int DISPENSE_TIMEOUT = 200,
  parameter int MAX_RETRY        = 2,
  // derived from NUM_PRODUCTS; not meant to be overridden
  parameter int ID_W = ($clog2(NUM_PRODUCTS) < 1) ? 1 : $clog2(NUM_PRODUCTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PRICE_W-1:0]              credit,
  input  logic [NUM_PRODUCTS*PRICE_W-1:0] price_vec,
  input  logic [NUM_PRODUCTS-1:0]         stock_empty,
  input  logic                            sel_valid,
  input  logic [ID_W-1:0]                 sel_id,
  input  logic                            cancel,
  input  logic                            product_dispense_done,
  input  logic                            change_dispense_done,
  output logic [2:0]                      state_out,
  output logic                            dispense_en,
  output logic [ID_W-1:0]                 dispense_id,
  output logic                            change_en,
  output logic [PRICE_W-1:0]              change_amount,
  output logic                            credit_clear,
  output logic                            sel_reject,
  output logic                            display_amount_en,
  output logic                            fault
);

  localparam int TMR_MAX = (SELECT_TIMEOUT > DISPENSE_TIMEOUT) ? SELECT_TIMEOUT : DISPENSE_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [TMR_W-1:0]   SEL_LIMIT  = TMR_W'(SELECT_TIMEOUT);
  localparam logic [TMR_W-1:0]   DISP_LIMIT = TMR_W'(DISPENSE_TIMEOUT);
  localparam logic [TMR_W-1:0]   TMR_ONE    = TMR_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE  = RETRY_W'(1);
  localparam logic [ID_W:0]      NP_ID      = (ID_W + 1)'(NUM_PRODUCTS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_COIN = 3'd1,
    SELECT    = 3'd2,
    DISPENSE  = 3'd3,
    CHANGE    = 3'd4,
    REFUND    = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t               state_q, state_nx;
  logic [TMR_W-1:0]     timer_q, timer_nx;
  logic [RETRY_W-1:0]   retry_q, retry_nx;
  logic                 gap_q, gap_nx;        // one-cycle dispense_en drop between attempts
  logic [PRICE_W-1:0]   change_q, change_nx;  // credit - price, latched on DISPENSE entry
  logic [PRICE_W-1:0]   paid_q, paid_nx;      // full credit, latched on DISPENSE entry
  logic [PRICE_W-1:0]   credit_q;             // previous credit, for timer reload
  logic [ID_W-1:0]      id_nx;
  logic [PRICE_W-1:0]   amount_nx;
  logic                 fault_nx, reject_nx;

  logic [PRICE_W-1:0]   price_arr [NUM_PRODUCTS];
  logic [PRICE_W-1:0]   sel_price;
  logic                 sel_ok, afford, credit_moved, sel_expired, disp_expired;

  for (genvar gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_price
    assign price_arr[gi] = price_vec[gi*PRICE_W +: PRICE_W];
  end

  // Range test first so an out-of-range id never relies on the stock lookup.
  assign sel_ok       = ({1'b0, sel_id} < NP_ID) && !stock_empty[sel_id];
  assign sel_price    = price_arr[dispense_id];
  assign afford       = (credit >= sel_price);
  assign credit_moved = (credit != credit_q);
  assign sel_expired  = (timer_q == SEL_LIMIT);
  assign disp_expired = (timer_q == DISP_LIMIT);
  assign state_out    = state_q;

  always_comb begin
    state_nx  = state_q;
    timer_nx  = timer_q;
    retry_nx  = retry_q;
    gap_nx    = 1'b0;
    id_nx     = dispense_id;
    change_nx = change_q;
    paid_nx   = paid_q;
    fault_nx  = fault;
    reject_nx = 1'b0;
    amount_nx = '0;

    case (state_q)
      IDLE: begin
        if (credit != '0) state_nx = WAIT_COIN;
      end
      WAIT_COIN: begin
        timer_nx = credit_moved ? '0 : timer_q + TMR_ONE;
        if (cancel) begin
          state_nx = REFUND;
        end else if (sel_expired) begin
          state_nx = (credit == '0) ? DONE : REFUND;
        end else if (sel_valid) begin
          if (sel_ok) begin
            id_nx    = sel_id;
            state_nx = SELECT;
          end else begin
            reject_nx = 1'b1;
          end
        end
      end
      SELECT: begin
        timer_nx = credit_moved ? '0 : timer_q + TMR_ONE;
        if (cancel) begin
          state_nx = REFUND;
        end else if (afford) begin
          change_nx = credit - sel_price;
          paid_nx   = credit;
          state_nx  = DISPENSE;
        end else if (sel_expired) begin
          state_nx = (credit == '0) ? DONE : REFUND;
        end else if (sel_valid) begin
          if (sel_ok) id_nx = sel_id;
          else        reject_nx = 1'b1;
        end
      end
      DISPENSE: begin
        // Completion is only honoured while the request is actually asserted,
        // and it beats a timer expiry on the same edge.
        if (gap_q) begin
          timer_nx = '0;
        end else if (product_dispense_done) begin
          state_nx = (change_q != '0) ? CHANGE : DONE;
        end else if (disp_expired) begin
          if (retry_q < RETRY_MAX) begin
            retry_nx = retry_q + RETRY_ONE;
            gap_nx   = 1'b1;
            timer_nx = '0;
          end else begin
            fault_nx = 1'b1;
            state_nx = REFUND;
          end
        end else begin
          timer_nx = timer_q + TMR_ONE;
        end
      end
      CHANGE, REFUND: begin
        if (change_dispense_done) state_nx = DONE;
      end
      DONE: begin
        retry_nx = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (state_nx != state_q) timer_nx = '0;

    // Payout amount is frozen at entry so later coin activity cannot alter it.
    if (state_nx == CHANGE) begin
      amount_nx = change_q;
    end else if (state_nx == REFUND) begin
      if (state_q == REFUND)        amount_nx = change_amount;
      else if (state_q == DISPENSE) amount_nx = paid_q;
      else                          amount_nx = credit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      timer_q           <= '0;
      retry_q           <= '0;
      gap_q             <= 1'b0;
      change_q          <= '0;
      paid_q            <= '0;
      credit_q          <= '0;
      dispense_id       <= '0;
      dispense_en       <= 1'b0;
      change_en         <= 1'b0;
      change_amount     <= '0;
      credit_clear      <= 1'b0;
      sel_reject        <= 1'b0;
      display_amount_en <= 1'b0;
      fault             <= 1'b0;
    end else begin
      state_q           <= state_nx;
      timer_q           <= timer_nx;
      retry_q           <= retry_nx;
      gap_q             <= gap_nx;
      change_q          <= change_nx;
      paid_q            <= paid_nx;
      credit_q          <= credit;
      dispense_id       <= id_nx;
      dispense_en       <= (state_nx == DISPENSE) && !gap_nx;
      change_en         <= (state_nx == CHANGE) || (state_nx == REFUND);
      change_amount     <= amount_nx;
      credit_clear      <= (state_nx == DONE);
      sel_reject        <= reject_nx;
      display_amount_en <= (state_nx == WAIT_COIN) || (state_nx == SELECT);
      fault             <= fault_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vend_fsm_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_fsm_ctrl_p
// Purpose  : Self-checking bench for vend_fsm_ctrl_p with a transaction-level
//            reference model (price table lookup and plain arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_fsm_ctrl_p;

  localparam int NP  = 4;
  localparam int PW  = 8;
  localparam int ST  = 20;
  localparam int DT  = 8;
  localparam int MR  = 1;
  localparam int IDW = 2;

  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_SEL = 3'd2, S_DISP = 3'd3,
                         S_CHG = 3'd4, S_REF = 3'd5, S_DONE = 3'd6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PW-1:0]     credit;
  logic [NP*PW-1:0]  price_vec;
  logic [NP-1:0]     stock_empty;
  logic              sel_valid, cancel, product_dispense_done, change_dispense_done;
  logic [IDW-1:0]    sel_id;
  logic [2:0]        state_out;
  logic              dispense_en, change_en, credit_clear, sel_reject, display_amount_en, fault;
  logic [IDW-1:0]    dispense_id;
  logic [PW-1:0]     change_amount;

  // Second instance with five products so that ids beyond the range exist.
  logic [PW-1:0]     credit2;
  logic              sel_valid2;
  logic [2:0]        sel_id2;
  logic [2:0]        state_out2, dispense_id2;
  logic              dispense_en2, change_en2, credit_clear2, sel_reject2, display2, fault2;
  logic [PW-1:0]     change_amount2;

  int tests = 0;
  int fails = 0;
  int price_tab [NP] = '{10, 20, 30, 40};

  logic [18:0] all_outs;
  assign all_outs = {state_out, dispense_en, dispense_id, change_en, change_amount,
                     credit_clear, sel_reject, display_amount_en, fault};

  vend_fsm_ctrl_p #(.NUM_PRODUCTS(NP), .PRICE_W(PW), .SELECT_TIMEOUT(ST),
                    .DISPENSE_TIMEOUT(DT), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .credit(credit), .price_vec(price_vec),
    .stock_empty(stock_empty), .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
    .product_dispense_done(product_dispense_done), .change_dispense_done(change_dispense_done),
    .state_out(state_out), .dispense_en(dispense_en), .dispense_id(dispense_id),
    .change_en(change_en), .change_amount(change_amount), .credit_clear(credit_clear),
    .sel_reject(sel_reject), .display_amount_en(display_amount_en), .fault(fault)
  );

  vend_fsm_ctrl_p #(.NUM_PRODUCTS(5), .PRICE_W(PW), .SELECT_TIMEOUT(ST),
                    .DISPENSE_TIMEOUT(DT), .MAX_RETRY(MR)) dut5 (
    .clk(clk), .rst_n(rst_n), .credit(credit2), .price_vec({5{8'd255}}),
    .stock_empty(5'b00000), .sel_valid(sel_valid2), .sel_id(sel_id2), .cancel(1'b0),
    .product_dispense_done(1'b0), .change_dispense_done(1'b0),
    .state_out(state_out2), .dispense_en(dispense_en2), .dispense_id(dispense_id2),
    .change_en(change_en2), .change_amount(change_amount2), .credit_clear(credit_clear2),
    .sel_reject(sel_reject2), .display_amount_en(display2), .fault(fault2)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference outcome of a selection: 0 = rejected, 1 = waits for more coins,
  // 2 = dispenses immediately.
  function automatic int model_outcome(int cr, int id, logic [NP-1:0] st);
    if (id >= NP || st[id]) return 0;
    if (cr >= price_tab[id]) return 2;
    return 1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    credit = '0; stock_empty = '0; sel_valid = 1'b0; sel_id = '0; cancel = 1'b0;
    product_dispense_done = 1'b0; change_dispense_done = 1'b0;
    credit2 = '0; sel_valid2 = 1'b0; sel_id2 = '0;
    price_vec = {8'd40, 8'd30, 8'd20, 8'd10};
    repeat (3) tick();
    tests++;
    if (all_outs !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (state_out !== S_IDLE || display_amount_en !== 1'b0) begin
      fails++; $display("FAIL reset_idle: state=%0d display=%b expected state 0 display 0", state_out, display_amount_en);
    end
  endtask

  task automatic test_purchase_change();
    credit = 8'd25; tick();
    tests++;
    if (state_out !== S_WAIT || display_amount_en !== 1'b1) begin
      fails++; $display("FAIL purchase_wait: state=%0d display=%b expected 1/1", state_out, display_amount_en);
    end
    sel_valid = 1'b1; sel_id = 2'd1; tick(); sel_valid = 1'b0;
    tests++;
    if (state_out !== S_SEL || dispense_id !== 2'd1 || sel_reject !== 1'b0) begin
      fails++; $display("FAIL purchase_select: state=%0d id=%0d rej=%b expected 2/1/0", state_out, dispense_id, sel_reject);
    end
    tick();
    tests++;
    if (state_out !== S_DISP || dispense_en !== 1'b1 || display_amount_en !== 1'b0) begin
      fails++; $display("FAIL purchase_dispense: state=%0d en=%b display=%b expected 3/1/0", state_out, dispense_en, display_amount_en);
    end
    tick(); tick();
    product_dispense_done = 1'b1; tick(); product_dispense_done = 1'b0;
    tests++;
    if (state_out !== S_CHG || change_en !== 1'b1 || change_amount !== 8'd5 || dispense_en !== 1'b0) begin
      fails++; $display("FAIL purchase_change: state=%0d chg_en=%b amt=%0d en=%b expected 4/1/5/0", state_out, change_en, change_amount, dispense_en);
    end
    change_dispense_done = 1'b1; tick(); change_dispense_done = 1'b0;
    tests++;
    if (state_out !== S_DONE || credit_clear !== 1'b1 || change_en !== 1'b0) begin
      fails++; $display("FAIL purchase_done: state=%0d clr=%b chg_en=%b expected 6/1/0", state_out, credit_clear, change_en);
    end
    credit = '0; tick();
    tests++;
    if (state_out !== S_IDLE || credit_clear !== 1'b0) begin
      fails++; $display("FAIL purchase_idle: state=%0d clr=%b expected 0/0", state_out, credit_clear);
    end
  endtask

  task automatic test_no_change();
    credit = 8'd10; tick();
    sel_valid = 1'b1; sel_id = 2'd3; tick(); sel_valid = 1'b0;
    tick(); tick();
    tests++;
    if (state_out !== S_SEL || dispense_en !== 1'b0) begin
      fails++; $display("FAIL short_credit_waits: state=%0d en=%b expected 2/0", state_out, dispense_en);
    end
    credit = 8'd40; tick();
    tests++;
    if (state_out !== S_DISP || dispense_en !== 1'b1 || dispense_id !== 2'd3) begin
      fails++; $display("FAIL topup_dispense: state=%0d en=%b id=%0d expected 3/1/3", state_out, dispense_en, dispense_id);
    end
    product_dispense_done = 1'b1; tick(); product_dispense_done = 1'b0;
    tests++;
    if (state_out !== S_DONE || credit_clear !== 1'b1 || change_en !== 1'b0) begin
      fails++; $display("FAIL exact_skip_change: state=%0d clr=%b chg_en=%b expected 6/1/0", state_out, credit_clear, change_en);
    end
    credit = '0; tick();
  endtask

  task automatic test_reject();
    stock_empty = 4'b0100; credit = 8'd30; credit2 = 8'd50; tick();
    sel_valid = 1'b1; sel_id = 2'd2; sel_valid2 = 1'b1; sel_id2 = 3'd5; tick();
    sel_valid = 1'b0; sel_valid2 = 1'b0;
    tests++;
    if (sel_reject !== 1'b1 || state_out !== S_WAIT) begin
      fails++; $display("FAIL soldout_reject: rej=%b state=%0d expected 1/1", sel_reject, state_out);
    end
    tests++;
    if (sel_reject2 !== 1'b1 || state_out2 !== S_WAIT) begin
      fails++; $display("FAIL range_reject: rej=%b state=%0d expected 1/1", sel_reject2, state_out2);
    end
    sel_valid2 = 1'b1; sel_id2 = 3'd4; tick(); sel_valid2 = 1'b0;
    tests++;
    if (sel_reject !== 1'b0 || state_out !== S_WAIT) begin
      fails++; $display("FAIL reject_one_cycle: rej=%b state=%0d expected 0/1", sel_reject, state_out);
    end
    tests++;
    if (state_out2 !== S_SEL || dispense_id2 !== 3'd4 || sel_reject2 !== 1'b0) begin
      fails++; $display("FAIL top_id_accept: state=%0d id=%0d rej=%b expected 2/4/0", state_out2, dispense_id2, sel_reject2);
    end
    cancel = 1'b1; tick(); cancel = 1'b0;
    tests++;
    if (state_out !== S_REF || change_amount !== 8'd30) begin
      fails++; $display("FAIL cancel_refund: state=%0d amt=%0d expected 5/30", state_out, change_amount);
    end
    change_dispense_done = 1'b1; tick(); change_dispense_done = 1'b0;
    credit = '0; stock_empty = '0; tick();
  endtask

  // Case 0: plain expiry. Case 1: credit change reloads the timer. Case 2:
  // credit drained to zero, so expiry finishes without a refund.
  task automatic test_timeout();
    int left_at, exp_leave;
    logic [PW-1:0] final_cr;
    for (int c = 0; c < 3; c++) begin
      credit = 8'd15; tick();
      final_cr = 8'd15;
      // From the entry edge the timer needs ST edges to reach the limit and
      // one more to leave; a reload edge restarts that count.
      exp_leave = ST + 1;
      if (c > 0) begin
        repeat (5) tick();
        final_cr = (c == 1) ? 8'd16 : 8'd0;
        credit = final_cr;
        exp_leave = ST + 2;
      end
      left_at = 0;
      for (int k = 1; k <= ST + 10; k++) begin
        tick();
        if (state_out !== S_WAIT) begin left_at = k; break; end
      end
      tests++;
      if (left_at != exp_leave) begin
        fails++; $display("FAIL timeout_cycles case%0d: left after %0d edges expected %0d", c, left_at, exp_leave);
      end
      if (c < 2) begin
        tests++;
        if (state_out !== S_REF || change_en !== 1'b1 || change_amount !== final_cr) begin
          fails++; $display("FAIL timeout_refund case%0d: state=%0d chg_en=%b amt=%0d expected 5/1/%0d", c, state_out, change_en, change_amount, final_cr);
        end
        change_dispense_done = 1'b1; tick(); change_dispense_done = 1'b0;
      end
      tests++;
      if (state_out !== S_DONE || credit_clear !== 1'b1) begin
        fails++; $display("FAIL timeout_done case%0d: state=%0d clr=%b expected 6/1", c, state_out, credit_clear);
      end
      credit = '0; tick();
    end
  endtask

  task automatic test_cancel_priority();
    stock_empty = 4'b0001; credit = 8'd20; tick();
    cancel = 1'b1; sel_valid = 1'b1; sel_id = 2'd0; tick();
    cancel = 1'b0; sel_valid = 1'b0;
    tests++;
    if (state_out !== S_REF || sel_reject !== 1'b0 || change_amount !== 8'd20) begin
      fails++; $display("FAIL cancel_beats_sel: state=%0d rej=%b amt=%0d expected 5/0/20", state_out, sel_reject, change_amount);
    end
    credit = 8'd90; tick();
    tests++;
    if (change_amount !== 8'd20) begin
      fails++; $display("FAIL refund_amount_frozen: amt=%0d expected 20", change_amount);
    end
    change_dispense_done = 1'b1; tick(); change_dispense_done = 1'b0;
    credit = '0; stock_empty = '0; tick();
  endtask

  task automatic test_retry_fault();
    logic [31:0] exp_pat, got_pat;
    int n;
    credit = 8'd30; tick();
    sel_valid = 1'b1; sel_id = 2'd2; tick(); sel_valid = 1'b0;
    tick();
    credit = 8'd99;
    // Each attempt holds the request DT+1 cycles (timer 0..DT); a one-cycle
    // gap separates attempts.
    exp_pat = '0; got_pat = '0; n = 0;
    for (int a = 0; a <= MR; a++) begin
      for (int j = 0; j <= DT; j++) begin exp_pat[n] = 1'b1; n++; end
      if (a < MR) begin exp_pat[n] = 1'b0; n++; end
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      got_pat[i] = dispense_en & (state_out == S_DISP);
    end
    tests++;
    if (got_pat !== exp_pat) begin
      fails++; $display("FAIL retry_pattern: got %b expected %b", got_pat, exp_pat);
    end
    tick();
    tests++;
    if (state_out !== S_REF || fault !== 1'b1 || change_amount !== 8'd30 || dispense_en !== 1'b0) begin
      fails++; $display("FAIL fault_refund: state=%0d fault=%b amt=%0d en=%b expected 5/1/30/0", state_out, fault, change_amount, dispense_en);
    end
    change_dispense_done = 1'b1; tick(); change_dispense_done = 1'b0;
    credit = '0; tick();
    tests++;
    if (state_out !== S_IDLE || fault !== 1'b1) begin
      fails++; $display("FAIL fault_sticky: state=%0d fault=%b expected 0/1", state_out, fault);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    tests++;
    if (fault !== 1'b0) begin
      fails++; $display("FAIL fault_cleared_by_reset: fault=%b expected 0", fault);
    end
  endtask

  task automatic test_back_to_back();
    int cr, id, outcome, d, chg;
    logic [NP-1:0] st;
    for (int t = 0; t < 16; t++) begin
      cr = int'($urandom_range(60, 1));
      id = int'($urandom_range(NP - 1, 0));
      st = NP'($urandom_range(15, 0));
      outcome = model_outcome(cr, id, st);
      chg = cr - price_tab[id];
      stock_empty = st; credit = PW'(cr); tick();
      sel_valid = 1'b1; sel_id = IDW'(id); tick(); sel_valid = 1'b0;
      tests++;
      if ((outcome == 0) ? (state_out !== S_WAIT || sel_reject !== 1'b1)
                         : (state_out !== S_SEL || dispense_id !== IDW'(id))) begin
        fails++; $display("FAIL rnd%0d_select: cr=%0d id=%0d st=%b state=%0d rej=%b model=%0d", t, cr, id, st, state_out, sel_reject, outcome);
      end
      if (outcome == 2) begin
        tick();
        d = int'($urandom_range(5, 1));
        repeat (d - 1) tick();
        product_dispense_done = 1'b1; tick(); product_dispense_done = 1'b0;
        tests++;
        if ((chg != 0) ? (state_out !== S_CHG || change_amount !== PW'(chg))
                       : (state_out !== S_DONE || credit_clear !== 1'b1)) begin
          fails++; $display("FAIL rnd%0d_vend: cr=%0d id=%0d state=%0d amt=%0d expected change %0d", t, cr, id, state_out, change_amount, chg);
        end
      end else begin
        if (outcome == 1) tick();
        cancel = 1'b1; tick(); cancel = 1'b0;
        tests++;
        if (state_out !== S_REF || change_amount !== PW'(cr)) begin
          fails++; $display("FAIL rnd%0d_refund: state=%0d amt=%0d expected 5/%0d", t, state_out, change_amount, cr);
        end
      end
      if (state_out == S_CHG || state_out == S_REF) begin
        change_dispense_done = 1'b1; tick(); change_dispense_done = 1'b0;
      end
      credit = '0; tick();
      tests++;
      if (state_out !== S_IDLE) begin
        fails++; $display("FAIL rnd%0d_idle: state=%0d expected 0", t, state_out);
      end
    end
    stock_empty = '0;
  endtask

  task automatic test_reset_mid();
    credit = 8'd25; tick();
    sel_valid = 1'b1; sel_id = 2'd1; tick(); sel_valid = 1'b0;
    tick();
    product_dispense_done = 1'b1; tick(); product_dispense_done = 1'b0;
    tests++;
    if (state_out !== S_CHG) begin
      fails++; $display("FAIL mid_reach_change: state=%0d expected 4", state_out);
    end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (all_outs !== '0) begin
      fails++; $display("FAIL async_reset: outputs %h expected 0 before next edge", all_outs);
    end
    credit = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (state_out !== S_IDLE || credit_clear !== 1'b0 || change_en !== 1'b0) begin
      fails++; $display("FAIL after_abort: state=%0d clr=%b chg_en=%b expected 0/0/0", state_out, credit_clear, change_en);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_purchase_change();
    test_no_change();
    test_reject();
    test_timeout();
    test_cancel_priority();
    test_retry_fault();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
